dmem_access_ctrl: RTL and testbench
===================================

Name: dmem_access_ctrl

Overview:
MEM-stage controller on the producing side of the MEM/WB pipeline register. It takes EX/MEM outputs and runs a req/ack handshake with a variable-latency data memory. While the access is outstanding it stalls upstream registers and feeds bubbles into MEM/WB. It then presents the completed result (read data, ALU result, destination register, WB controls) on the exact signals MEM/WB captures.

Parameters:
TIMEOUT_CYCLES, 255, BUSY cycles without DM_Ack before the access is aborted
CNT_W, 8, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES

Ports:
Clk  in  1  single clock, rising edge
Rst_n  in  1  asynchronous, active-low reset
MemRead_In  in  1  EX/MEM load control
MemWrite_In  in  1  EX/MEM store control
Address_In  in  32  EX/MEM ALU result, used as memory address
WriteData_In  in  32  EX/MEM store data
WriteReg_In  in  5  EX/MEM destination register
RegWrite_In  in  1  EX/MEM RegWrite
MemtoReg_In  in  1  EX/MEM MemtoReg
DM_Req  out  1  memory request, held until ack or timeout
DM_We  out  1  1 = write, 0 = read; valid with DM_Req
DM_Addr  out  32  held address
DM_WData  out  32  held store data
DM_Ack  in  1  single-cycle completion strobe from memory
DM_RData  in  32  read data, valid when DM_Ack=1
DM_RD  out  32  to MEM/WB read-data input
ALUResult_Out  out  32  to MEM/WB ALU-result input
WR_Out  out  5  to MEM/WB destination register
RW_Out  out  1  to MEM/WB RegWrite
MtR_Out  out  1  to MEM/WB MemtoReg
C_MemRead  out  1  to MEM/WB MemRead
Stall  out  1  freeze PC, IF/ID, ID/EX and EX/MEM this cycle
Timeout_Err  out  1  sticky abort flag

Behaviour:
- FSM states: IDLE, BUSY, DONE. Reset puts the FSM in IDLE.
- On reset: all held registers = 0, DM_Req = 0, counter = 0, Timeout_Err = 0.
- Reset asserted mid-access drops DM_Req immediately (asynchronously). A DM_Ack that arrives afterwards is ignored.
- IDLE, no memory op (MemRead_In = MemWrite_In = 0):
  - Combinational pass-through: ALUResult_Out = Address_In, WR_Out/RW_Out/MtR_Out from the inputs, DM_RD = 0, C_MemRead = 0.
  - Stall = 0. Zero added latency.
- IDLE, memory op present:
  - Stall = 1 combinationally. MEM/WB outputs are a bubble (RW_Out = MtR_Out = C_MemRead = 0, data/WR = 0).
  - Latch address, data, WriteReg, RegWrite, MemtoReg and op type. Go to BUSY.
  - MemRead_In and MemWrite_In both 1: treat as a write (DM_We = 1, held MemRead = 0).
- BUSY:
  - DM_Req = 1; DM_We, DM_Addr and DM_WData come from the held registers and stay stable.
  - Stall = 1; outputs are a bubble; the counter increments each cycle.
- BUSY, DM_Ack = 1: capture DM_RData (reads) or 0 (writes) into the data register. Go to DONE; counter clears.
- BUSY, counter reaches TIMEOUT_CYCLES-1 with no ack:
  - Set Timeout_Err, capture data 0, go to DONE.
  - DM_Ack in that same cycle wins: data is captured and Timeout_Err is not set.
- DONE:
  - DM_Req = 0, Stall = 0.
  - Outputs come from held registers: DM_RD = captured data, ALUResult_Out = held address, WR_Out, RW_Out and MtR_Out held, C_MemRead = held read flag.
  - EX/MEM inputs are ignored this cycle (they still show the completed instruction). Always return to IDLE.
- Latency: memory op occupies 2 + N cycles, where N = BUSY cycles up to and including the ack (N ≥ 1). A zero-wait memory gives 3 cycles and 2 stall cycles.
- DM_Ack outside BUSY: ignored.
- Timeout_Err clears only on reset.

Decomposition:
- Shared package dmem_pkg holds:
  - state encoding constants (IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2);
  - the bubble value (32'h0);
  - the TIMEOUT_CYCLES default.
- One sub-module, dmem_timeout_ctr: clear/enable counter with a terminal-count output.

Test Plan:
- ALU op, Address_In = 32'h1234, WriteReg_In = 5'd8, RegWrite_In = 1 in IDLE -> same cycle: ALUResult_Out = 32'h1234, WR_Out = 8, RW_Out = 1, Stall = 0, DM_Req = 0.
- Load at 32'h40, DM_Ack on the 3rd BUSY cycle with DM_RData = 32'hCAFEF00D -> Stall high for 4 cycles; then in DONE: DM_RD = 32'hCAFEF00D, C_MemRead = 1, MtR_Out = 1; bubbles before that.
- Store at 32'h80 with data 32'hA5A5A5A5, ack after 1 cycle -> DM_We = 1, DM_WData held stable; in DONE: RW_Out = 0, DM_RD = 0, 3 cycles total.
- Load with no ack, TIMEOUT_CYCLES = 4 -> DM_Req drops after 4 BUSY cycles, Timeout_Err = 1 and stays set through later ops, DM_RD = 0.
- Rst_n low in the 2nd BUSY cycle, then a late DM_Ack -> DM_Req = 0 immediately; FSM in IDLE, no output change.
- Back-to-back loads with ack in the 1st BUSY cycle -> second load enters BUSY 3 cycles after the first; both data values appear in DONE in order.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the MEM-stage data-memory access controller.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [31:0] BUBBLE          = 32'h0;
  localparam int unsigned TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/dmem_timeout_ctr.sv
// Clear/enable cycle counter; tc flags the last allowed cycle while enabled.
module dmem_timeout_ctr #(
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned TERMINAL = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count <= '0;
    else if (clr)
      count <= '0;
    else if (en)
      count <= count + CNT_W'(1);
  end

  assign tc = en && (count == CNT_W'(TERMINAL - 1));

endmodule

// File: rtl/dmem_access_ctrl.sv
// MEM-stage req/ack controller: holds the EX/MEM op, stalls upstream and
// feeds MEM/WB bubbles until the variable-latency data memory completes.
module dmem_access_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
  parameter int unsigned CNT_W          = 8
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        MemRead_In,
  input  logic        MemWrite_In,
  input  logic [31:0] Address_In,
  input  logic [31:0] WriteData_In,
  input  logic [4:0]  WriteReg_In,
  input  logic        RegWrite_In,
  input  logic        MemtoReg_In,
  output logic        DM_Req,
  output logic        DM_We,
  output logic [31:0] DM_Addr,
  output logic [31:0] DM_WData,
  input  logic        DM_Ack,
  input  logic [31:0] DM_RData,
  output logic [31:0] DM_RD,
  output logic [31:0] ALUResult_Out,
  output logic [4:0]  WR_Out,
  output logic        RW_Out,
  output logic        MtR_Out,
  output logic        C_MemRead,
  output logic        Stall,
  output logic        Timeout_Err
);

  state_t      state, state_nxt;
  logic [31:0] addr_q, wdata_q, data_q;
  logic [4:0]  wreg_q;
  logic        rw_q, mtr_q, rd_q, we_q, err_q;
  logic        mem_op, busy, tc, finish;

  assign mem_op = MemRead_In | MemWrite_In;
  assign busy   = (state == BUSY);
  assign finish = busy & (DM_Ack | tc);

  dmem_timeout_ctr #(
    .CNT_W    (CNT_W),
    .TERMINAL (TIMEOUT_CYCLES)
  ) u_timeout_ctr (
    .clk   (Clk),
    .rst_n (Rst_n),
    .clr   (finish),
    .en    (busy),
    .tc    (tc)
  );

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    DM_Req        = 1'b0;
    Stall         = 1'b0;
    DM_RD         = BUBBLE;
    ALUResult_Out = BUBBLE;
    WR_Out        = '0;
    RW_Out        = 1'b0;
    MtR_Out       = 1'b0;
    C_MemRead     = 1'b0;
    case (state)
      IDLE: begin
        if (mem_op) begin
          Stall     = 1'b1;
          state_nxt = BUSY;
        end else begin
          ALUResult_Out = Address_In;
          WR_Out        = WriteReg_In;
          RW_Out        = RegWrite_In;
          MtR_Out       = MemtoReg_In;
        end
      end
      BUSY: begin
        DM_Req = 1'b1;
        Stall  = 1'b1;
        if (DM_Ack || tc)
          state_nxt = DONE;
      end
      DONE: begin
        DM_RD         = data_q;
        ALUResult_Out = addr_q;
        WR_Out        = wreg_q;
        RW_Out        = rw_q;
        MtR_Out       = mtr_q;
        C_MemRead     = rd_q;
        state_nxt     = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Simultaneous read+write requests are executed as a write.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      data_q  <= '0;
      wreg_q  <= '0;
      rw_q    <= 1'b0;
      mtr_q   <= 1'b0;
      rd_q    <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (state == IDLE && mem_op) begin
        addr_q  <= Address_In;
        wdata_q <= WriteData_In;
        wreg_q  <= WriteReg_In;
        rw_q    <= RegWrite_In;
        mtr_q   <= MemtoReg_In;
        we_q    <= MemWrite_In;
        rd_q    <= MemRead_In & ~MemWrite_In;
      end
      if (finish)
        data_q <= (DM_Ack && rd_q) ? DM_RData : BUBBLE;
      if (busy && tc && !DM_Ack)
        err_q <= 1'b1;
    end
  end

  assign DM_We       = we_q;
  assign DM_Addr     = addr_q;
  assign DM_WData    = wdata_q;
  assign Timeout_Err = err_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl against a transaction-level model.
module tb_dmem_access_ctrl;

  localparam int unsigned TO = 4;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        MemRead_In = 1'b0, MemWrite_In = 1'b0;
  logic [31:0] Address_In = '0, WriteData_In = '0;
  logic [4:0]  WriteReg_In = '0;
  logic        RegWrite_In = 1'b0, MemtoReg_In = 1'b0;
  logic        DM_Req, DM_We;
  logic [31:0] DM_Addr, DM_WData;
  logic        DM_Ack = 1'b0;
  logic [31:0] DM_RData = '0;
  logic [31:0] DM_RD, ALUResult_Out;
  logic [4:0]  WR_Out;
  logic        RW_Out, MtR_Out, C_MemRead, Stall, Timeout_Err;

  int tests = 0;
  int fails = 0;
  bit model_err = 1'b0;

  dmem_access_ctrl #(
    .TIMEOUT_CYCLES (TO),
    .CNT_W          (3)
  ) dut (
    .Clk (Clk), .Rst_n (Rst_n),
    .MemRead_In (MemRead_In), .MemWrite_In (MemWrite_In),
    .Address_In (Address_In), .WriteData_In (WriteData_In),
    .WriteReg_In (WriteReg_In), .RegWrite_In (RegWrite_In), .MemtoReg_In (MemtoReg_In),
    .DM_Req (DM_Req), .DM_We (DM_We), .DM_Addr (DM_Addr), .DM_WData (DM_WData),
    .DM_Ack (DM_Ack), .DM_RData (DM_RData),
    .DM_RD (DM_RD), .ALUResult_Out (ALUResult_Out), .WR_Out (WR_Out),
    .RW_Out (RW_Out), .MtR_Out (MtR_Out), .C_MemRead (C_MemRead),
    .Stall (Stall), .Timeout_Err (Timeout_Err)
  );

  always #5 Clk = ~Clk;

  task automatic drive_idle();
    MemRead_In   = 1'b0;
    MemWrite_In  = 1'b0;
    Address_In   = '0;
    WriteData_In = '0;
    WriteReg_In  = '0;
    RegWrite_In  = 1'b0;
    MemtoReg_In  = 1'b0;
  endtask

  // One memory transaction from IDLE to the following IDLE; ack_at is the
  // BUSY cycle (1-based) carrying DM_Ack, 0 meaning the memory never answers.
  task automatic run_mem_op(input bit is_rd, input bit is_wr, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [4:0] wreg,
                            input bit rw, input bit mtr, input int unsigned ack_at,
                            input logic [31:0] rdata, input string tag);
    bit          exp_rd, timed_out;
    int unsigned n;
    logic [31:0] exp_data;
    exp_rd    = is_rd && !is_wr;
    timed_out = (ack_at == 0) || (ack_at > TO);
    n         = timed_out ? TO : ack_at;
    exp_data  = (timed_out || !exp_rd) ? 32'h0 : rdata;

    MemRead_In = is_rd; MemWrite_In = is_wr; Address_In = addr; WriteData_In = wdata;
    WriteReg_In = wreg; RegWrite_In = rw; MemtoReg_In = mtr;
    @(negedge Clk);
    tests++;
    if ({Stall, DM_Req} !== 2'b10)
      $display("FAIL %s idle stall/req got %b exp 10", tag, {Stall, DM_Req});
    tests++;
    if ({DM_RD, ALUResult_Out, WR_Out, RW_Out, MtR_Out, C_MemRead} !== 72'h0)
      $display("FAIL %s idle bubble got %h/%h/%h/%b%b%b exp zeros", tag, DM_RD,
               ALUResult_Out, WR_Out, RW_Out, MtR_Out, C_MemRead);
    if ({Stall, DM_Req} !== 2'b10 ||
        {DM_RD, ALUResult_Out, WR_Out, RW_Out, MtR_Out, C_MemRead} !== 72'h0) fails++;

    for (int unsigned k = 1; k <= n; k++) begin
      @(posedge Clk); #1;
      DM_Ack   = (k == ack_at);
      DM_RData = (k == ack_at) ? rdata : $urandom;
      @(negedge Clk);
      tests++;
      if ({DM_Req, Stall, DM_We} !== {2'b11, is_wr}) begin
        fails++;
        $display("FAIL %s busy%0d req/stall/we got %b exp %b", tag, k,
                 {DM_Req, Stall, DM_We}, {2'b11, is_wr});
      end
      tests++;
      if (DM_Addr !== addr || DM_WData !== wdata) begin
        fails++;
        $display("FAIL %s busy%0d addr/wdata got %h/%h exp %h/%h", tag, k,
                 DM_Addr, DM_WData, addr, wdata);
      end
      tests++;
      if ({DM_RD, ALUResult_Out, WR_Out, RW_Out, MtR_Out, C_MemRead} !== 72'h0) begin
        fails++;
        $display("FAIL %s busy%0d bubble got %h/%h exp zeros", tag, k, DM_RD, ALUResult_Out);
      end
    end
    if (timed_out) model_err = 1'b1;

    // EX/MEM contents during DONE must not matter.
    @(posedge Clk); #1;
    DM_Ack = 1'b0;
    MemRead_In = 1'($urandom); MemWrite_In = 1'($urandom); Address_In = $urandom;
    WriteData_In = $urandom; WriteReg_In = 5'($urandom);
    RegWrite_In = 1'($urandom); MemtoReg_In = 1'($urandom);
    @(negedge Clk);
    tests++;
    if ({DM_Req, Stall} !== 2'b00) begin
      fails++;
      $display("FAIL %s done req/stall got %b exp 00", tag, {DM_Req, Stall});
    end
    tests++;
    if (DM_RD !== exp_data) begin
      fails++;
      $display("FAIL %s done rd got %h exp %h", tag, DM_RD, exp_data);
    end
    tests++;
    if (ALUResult_Out !== addr) begin
      fails++;
      $display("FAIL %s done alu got %h exp %h", tag, ALUResult_Out, addr);
    end
    tests++;
    if ({WR_Out, RW_Out, MtR_Out, C_MemRead} !== {wreg, rw, mtr, exp_rd}) begin
      fails++;
      $display("FAIL %s done wr/rw/mtr/mr got %b exp %b", tag,
               {WR_Out, RW_Out, MtR_Out, C_MemRead}, {wreg, rw, mtr, exp_rd});
    end
    tests++;
    if (Timeout_Err !== model_err) begin
      fails++;
      $display("FAIL %s done timeout_err got %b exp %b", tag, Timeout_Err, model_err);
    end
    @(posedge Clk); #1;
    drive_idle();
  endtask

  task automatic test_reset();
    drive_idle();
    Rst_n = 1'b0;
    #1;
    tests++;
    if ({DM_Req, Stall, Timeout_Err, DM_We} !== 4'b0000) begin
      fails++;
      $display("FAIL reset flags got %b exp 0000", {DM_Req, Stall, Timeout_Err, DM_We});
    end
    tests++;
    if ({DM_Addr, DM_WData, DM_RD} !== 96'h0) begin
      fails++;
      $display("FAIL reset regs got %h/%h/%h exp zeros", DM_Addr, DM_WData, DM_RD);
    end
    model_err = 1'b0;
    @(negedge Clk); Rst_n = 1'b1;
    @(posedge Clk); #1;
  endtask

  task automatic test_alu_passthrough();
    for (int i = 0; i < 5; i++) begin
      drive_idle();
      Address_In  = (i == 0) ? 32'h1234 : $urandom;
      WriteReg_In = (i == 0) ? 5'd8 : 5'($urandom);
      RegWrite_In = (i == 0) ? 1'b1 : 1'($urandom);
      MemtoReg_In = (i == 0) ? 1'b0 : 1'($urandom);
      WriteData_In = $urandom;
      #1;
      tests++;
      if (ALUResult_Out !== Address_In ||
          {WR_Out, RW_Out, MtR_Out} !== {WriteReg_In, RegWrite_In, MemtoReg_In}) begin
        fails++;
        $display("FAIL alu%0d pass got %h/%b exp %h/%b", i, ALUResult_Out,
                 {WR_Out, RW_Out, MtR_Out}, Address_In, {WriteReg_In, RegWrite_In, MemtoReg_In});
      end
      tests++;
      if ({Stall, DM_Req, C_MemRead, Timeout_Err} !== {3'b000, model_err} || DM_RD !== 32'h0) begin
        fails++;
        $display("FAIL alu%0d ctl got %b rd %h exp %b rd 0", i,
                 {Stall, DM_Req, C_MemRead, Timeout_Err}, DM_RD, {3'b000, model_err});
      end
      @(posedge Clk); #1;
    end
  endtask

  task automatic test_load();
    run_mem_op(1'b1, 1'b0, 32'h40, 32'h0, 5'd9, 1'b1, 1'b1, 3, 32'hCAFEF00D, "load");
  endtask

  task automatic test_store();
    run_mem_op(1'b0, 1'b1, 32'h80, 32'hA5A5A5A5, 5'd3, 1'b0, 1'b0, 1, 32'h11223344, "store");
    run_mem_op(1'b1, 1'b1, 32'h84, 32'h5A5A5A5A, 5'd4, 1'b1, 1'b1, 2, 32'hDEADBEEF, "rd_wr_both");
  endtask

  task automatic test_ack_at_limit();
    run_mem_op(1'b1, 1'b0, 32'hC0, 32'h0, 5'd12, 1'b1, 1'b1, TO, 32'h0BADF00D, "ack_at_limit");
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++) begin
      bit rd, wr;
      rd = 1'($urandom);
      wr = rd ? 1'($urandom) : 1'b1;
      run_mem_op(rd, wr, $urandom, $urandom, 5'($urandom), 1'($urandom), 1'($urandom),
                 $urandom_range(TO, 1), $urandom, "random");
    end
  endtask

  task automatic test_back_to_back();
    run_mem_op(1'b1, 1'b0, 32'h100, 32'h0, 5'd5, 1'b1, 1'b1, 1, 32'h01234567, "b2b_first");
    run_mem_op(1'b1, 1'b0, 32'h104, 32'h0, 5'd6, 1'b1, 1'b1, 1, 32'h89ABCDEF, "b2b_second");
  endtask

  task automatic test_timeout();
    run_mem_op(1'b1, 1'b0, 32'h200, 32'h0, 5'd7, 1'b1, 1'b1, 0, 32'hFFFFFFFF, "timeout");
    run_mem_op(1'b0, 1'b1, 32'h204, 32'h77, 5'd0, 1'b0, 1'b0, 2, 32'h0, "after_timeout");
    tests++;
    if (Timeout_Err !== 1'b1) begin
      fails++;
      $display("FAIL sticky_err got %b exp 1", Timeout_Err);
    end
  endtask

  task automatic test_reset_mid_access();
    MemRead_In = 1'b1; Address_In = 32'h300; WriteReg_In = 5'd10; RegWrite_In = 1'b1;
    MemtoReg_In = 1'b1;
    @(posedge Clk); #1;
    @(posedge Clk); #3;
    Rst_n = 1'b0;
    #1;
    tests++;
    if ({DM_Req, Timeout_Err} !== 2'b00 || DM_Addr !== 32'h0) begin
      fails++;
      $display("FAIL rst_mid async got req/err %b addr %h exp 00 addr 0",
               {DM_Req, Timeout_Err}, DM_Addr);
    end
    model_err = 1'b0;
    drive_idle();
    @(negedge Clk); Rst_n = 1'b1;
    @(posedge Clk); #1;
    DM_Ack = 1'b1; DM_RData = 32'hFEEDFACE; Address_In = 32'h55;
    @(negedge Clk);
    tests++;
    if ({DM_Req, Stall} !== 2'b00 || DM_RD !== 32'h0 || ALUResult_Out !== 32'h55) begin
      fails++;
      $display("FAIL rst_mid late_ack got req/stall %b rd %h alu %h exp 00 0 55",
               {DM_Req, Stall}, DM_RD, ALUResult_Out);
    end
    @(posedge Clk); #1;
    DM_Ack = 1'b0;
    @(negedge Clk);
    tests++;
    if ({DM_Req, Stall, C_MemRead} !== 3'b000 || DM_RD !== 32'h0) begin
      fails++;
      $display("FAIL rst_mid after got req/stall/mr %b rd %h exp 000 0",
               {DM_Req, Stall, C_MemRead}, DM_RD);
    end
    @(posedge Clk); #1;
  endtask

  initial begin
    test_reset();
    test_alu_passthrough();
    test_load();
    test_store();
    test_ack_at_limit();
    test_random();
    test_back_to_back();
    test_timeout();
    test_alu_passthrough();
    test_reset_mid_access();
    test_alu_passthrough();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    fails++;
    $display("FAIL watchdog expired got running exp finished");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
